// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-file write port between
// the ALU and LSU, plus a destination-register busy scoreboard for RAW stalls.
module core_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ALU_VALID,
  output logic              ALU_READY,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  input  logic              LSU_VALID,
  output logic              LSU_READY,
  input  logic [ADDR_W-1:0] LSU_ADDR,
  input  logic [DATA_W-1:0] LSU_DATA,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  input  logic [ADDR_W-1:0] QADDR1,
  input  logic [ADDR_W-1:0] QADDR2,
  output logic              QBUSY1,
  output logic              QBUSY2,
  output logic              AWVALID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic              ERR
);

  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_t;

  pri_t              r_pri;
  pri_t              w_pri_nxt;
  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              r_awvalid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_err_set;
  logic              r_err;

  // Round-robin priority pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pri <= PRI_ALU;
    else     r_pri <= w_pri_nxt;
  end

  // Grant selection; any grant hands priority to the other source
  always_comb begin
    w_pri_nxt = r_pri;
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!RST) begin
      if (ALU_VALID && (!LSU_VALID || (r_pri == PRI_ALU))) w_alu_gnt = 1'b1;
      else if (LSU_VALID)                                 w_lsu_gnt = 1'b1;
    end
    if (w_alu_gnt)      w_pri_nxt = PRI_LSU;
    else if (w_lsu_gnt) w_pri_nxt = PRI_ALU;
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      r_awvalid <= w_alu_gnt | w_lsu_gnt;
      if (w_alu_gnt) begin
        r_awaddr <= ALU_ADDR;
        r_wdata  <= ALU_DATA;
      end else if (w_lsu_gnt) begin
        r_awaddr <= LSU_ADDR;
        r_wdata  <= LSU_DATA;
      end
    end
  end

  // Clear on the register-file write edge, then set from issue so a newer producer wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_awvalid) w_busy_nxt[r_awaddr] = 1'b0;
    if (ISSUE_VALID && (ISSUE_ADDR != '0)) w_busy_nxt[ISSUE_ADDR] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_err_set = r_awvalid && (r_awaddr != '0) && !r_busy[r_awaddr];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign ALU_READY = w_alu_gnt;
  assign LSU_READY = w_lsu_gnt;
  assign QBUSY1    = r_busy[QADDR1];
  assign QBUSY2    = r_busy[QADDR2];
  assign AWVALID   = r_awvalid;
  assign AWADDR    = r_awaddr;
  assign WDATA     = r_wdata;
  assign ERR       = r_err;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of arbitration and scoreboard.
module tb_core_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ALU_VALID = 1'b0, LSU_VALID = 1'b0, ISSUE_VALID = 1'b0;
  logic          ALU_READY, LSU_READY, QBUSY1, QBUSY2, AWVALID, ERR;
  logic [AW-1:0] ALU_ADDR = '0, LSU_ADDR = '0, ISSUE_ADDR = '0;
  logic [AW-1:0] QADDR1 = '0, QADDR2 = '0, AWADDR;
  logic [DW-1:0] ALU_DATA = '0, LSU_DATA = '0, WDATA;

  core_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_ADDR(LSU_ADDR), .LSU_DATA(LSU_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR),
    .QADDR1(QADDR1), .QADDR2(QADDR2), .QBUSY1(QBUSY1), .QBUSY2(QBUSY2),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .WDATA(WDATA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_chk = 0;
  int            n_fail = 0;

  // Reference model state: which registers are owed a write, sticky error,
  // who was served last, and the write the register file is about to latch.
  bit            m_busy[32];
  bit            m_err;
  bit            last_was_lsu;
  bit            m_pw_v;
  logic [AW-1:0] m_pw_a;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;
  bit            act_ag, act_lg;
  bit            ag, lg;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err        = 1'b0;
    last_was_lsu = 1'b1;
    m_pw_v       = 1'b0;
    m_pw_a       = '0;
  endtask

  // One clock cycle: drive, check combinational outputs against the model,
  // record the expected write and advance the model across the coming edge.
  task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit iv, input logic [AW-1:0] ia,
                       input logic [AW-1:0] q1, input logic [AW-1:0] q2,
                       output bit g_a, output bit g_l);
    @(negedge CLK);
    ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
    LSU_VALID = lv; LSU_ADDR = la; LSU_DATA = ld;
    ISSUE_VALID = iv; ISSUE_ADDR = ia;
    QADDR1 = q1; QADDR2 = q2;
    #1;
    g_a = av && (!lv || last_was_lsu);
    g_l = lv && !g_a;
    chk("alu_ready", 32'(ALU_READY), 32'(g_a));
    chk("lsu_ready", 32'(LSU_READY), 32'(g_l));
    chk("qbusy1", 32'(QBUSY1), 32'(m_busy[q1]));
    chk("qbusy2", 32'(QBUSY2), 32'(m_busy[q2]));
    chk("err", 32'(ERR), 32'(m_err));
    act_ag = ALU_READY;
    act_lg = LSU_READY;
    if (m_pw_v && m_pw_a != '0) begin
      if (!m_busy[m_pw_a]) m_err = 1'b1;
      m_busy[m_pw_a] = 1'b0;
    end
    if (iv && ia != '0) m_busy[ia] = 1'b1;
    m_pw_v = g_a || g_l;
    m_pw_a = g_a ? aa : la;
    if (g_a) begin
      exp_q.push_back({aa, ad});
      last_was_lsu = 1'b0;
    end else if (g_l) begin
      exp_q.push_back({la, ld});
      last_was_lsu = 1'b1;
    end
  endtask

  task automatic idle(input logic [AW-1:0] q1);
    bit x, y;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, q1, 5'd0, x, y);
  endtask

  task automatic issue(input logic [AW-1:0] ia);
    bit x, y;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, ia, ia, 5'd0, x, y);
  endtask

  // Mid-cycle asynchronous reset pulse with both requesters asserting
  task automatic do_reset();
    @(negedge CLK);
    ALU_VALID = 1'b1; LSU_VALID = 1'b1; ALU_ADDR = 5'd3; LSU_ADDR = 5'd7;
    QADDR1 = 5'd3; QADDR2 = 5'd9;
    #2 RST = 1'b1;
    #1;
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_awaddr", 32'(AWADDR), 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_qbusy1", 32'(QBUSY1), 32'd0);
    chk("rst_qbusy2", 32'(QBUSY2), 32'd0);
    chk("rst_alu_ready", 32'(ALU_READY), 32'd0);
    chk("rst_lsu_ready", 32'(LSU_READY), 32'd0);
    model_reset();
    exp_q.delete();
    hold_a = '0;
    hold_d = '0;
    ALU_VALID = 1'b0; LSU_VALID = 1'b0; ISSUE_VALID = 1'b0;
    #1 RST = 1'b0;
  endtask

  // Monitor: every register-file write must match the oldest expected write
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (AWVALID) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL aw_unexpected: got write a=%0d d=%0h expected none", AWADDR, WDATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("awaddr", 32'(AWADDR), 32'(mon_e.a));
          chk("wdata", WDATA, mon_e.d);
          hold_a = mon_e.a;
          hold_d = mon_e.d;
        end
      end else begin
        chk("aw_missing", 32'(exp_q.size()), 32'd0);
        chk("awaddr_hold", 32'(AWADDR), 32'(hold_a));
        chk("wdata_hold", WDATA, hold_d);
      end
    end
  end

  logic [AW-1:0] a_adr[4];
  logic [AW-1:0] l_adr[4];
  bit            pa_v, pl_v, r_iv;
  logic [AW-1:0] pa_a, pl_a, r_ia;
  logic [DW-1:0] pa_d, pl_d;

  initial begin
    int ai, li;
    model_reset();
    #1 RST = 1'b1;
    #2 RST = 1'b0;
    do_reset();

    // Single ALU writeback to x5
    issue(5'd5);
    idle(5'd5);
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd0, ag, lg);
    chk("x5_grant", 32'(act_ag), 32'd1);
    idle(5'd5);
    chk("x5_busy_during_write", 32'(QBUSY1), 32'd1);
    idle(5'd5);
    chk("x5_cleared", 32'(QBUSY1), 32'd0);
    chk("x5_err", 32'(ERR), 32'd0);

    // Contention: both always valid, grants alternate starting with ALU
    do_reset();
    a_adr[0] = 5'd3; a_adr[1] = 5'd4; a_adr[2] = 5'd5; a_adr[3] = 5'd6;
    l_adr[0] = 5'd7; l_adr[1] = 5'd8; l_adr[2] = 5'd10; l_adr[3] = 5'd11;
    for (int i = 0; i < 4; i++) issue(a_adr[i]);
    for (int i = 0; i < 3; i++) issue(l_adr[i]);
    ai = 0;
    li = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, a_adr[ai], 32'h11 + 32'(ai) * 32'h100, 1'b1, l_adr[li], 32'h22 + 32'(li) * 32'h100,
            1'b0, '0, 5'd0, 5'd0, ag, lg);
      chk("rr_order", 32'(act_ag), 32'((i % 2) == 0));
      if (ag) ai++;
      if (lg) li++;
    end
    idle(5'd0);
    idle(5'd0);

    // Same-edge clear and re-issue of x9: set wins
    issue(5'd9);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd0, ag, lg);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0, ag, lg);
    idle(5'd9);
    chk("x9_set_wins", 32'(QBUSY1), 32'd1);

    // x0 is never busy and its writes are harmless
    do_reset();
    issue(5'd0);
    idle(5'd0);
    chk("x0_never_busy", 32'(QBUSY1), 32'd0);
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0, ag, lg);
    chk("x0_grant", 32'(act_ag), 32'd1);
    idle(5'd0);
    idle(5'd0);
    chk("x0_no_err", 32'(ERR), 32'd0);

    // Spurious LSU writeback to idle x12 sets sticky ERR
    cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, '0, 5'd12, 5'd0, ag, lg);
    chk("x12_grant", 32'(act_lg), 32'd1);
    idle(5'd12);
    chk("x12_err_not_yet", 32'(ERR), 32'd0);
    idle(5'd12);
    chk("x12_err_set", 32'(ERR), 32'd1);
    idle(5'd0);
    idle(5'd0);
    chk("x12_err_sticky", 32'(ERR), 32'd1);

    // Random traffic; requesters hold until granted, reset dropped in midway
    do_reset();
    pa_v = 1'b0;
    pl_v = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        pa_v = 1'b0;
        pl_v = 1'b0;
      end
      if (!pa_v && $urandom_range(0, 1) == 1) begin
        pa_v = 1'b1; pa_a = AW'($urandom); pa_d = $urandom;
      end
      if (!pl_v && $urandom_range(0, 1) == 1) begin
        pl_v = 1'b1; pl_a = AW'($urandom); pl_d = $urandom;
      end
      r_iv = ($urandom_range(0, 1) == 1);
      r_ia = AW'($urandom);
      cycle(pa_v, pa_a, pa_d, pl_v, pl_a, pl_d, r_iv, r_ia, AW'($urandom), AW'($urandom), ag, lg);
      if (ag) pa_v = 1'b0;
      if (lg) pl_v = 1'b0;
    end
    idle(5'd0);
    idle(5'd0);
    idle(5'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
